// File: rtl/iddr2_ctrl_pkg.sv
// Shared definitions for the IDDR2 alignment controller.
//   state_t      : FSM state encoding, also exported on the STATE debug port
//   ORI_NORM/SWAP: candidate orientation (0 = Q0 early, 1 = Q1 early)
//   cnt_w()      : counter width for a count limit n ($clog2(n) + 1 bits)
package iddr2_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_HUNT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam logic ORI_NORM = 1'b0;
  localparam logic ORI_SWAP = 1'b1;

  // The extra bit lets a counter hold the limit value itself without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/iddr2_pattern_det.sv
// Training-pattern detector for the IDDR2 bank.
// Classifies each sample as "normal" (Q0 all ones, Q1 all zeros), "swapped"
// (Q0 all zeros, Q1 all ones) or neither, and tracks how many consecutive
// samples of the same orientation have been seen.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : count only while high; registers are cleared while low
//   q0, q1      : current IDDR2 sample, one bit per lane
//   match_done  : the current sample completes a run of MATCH_CNT matches
//   cand        : orientation of the run including the current sample
module iddr2_pattern_det
  import iddr2_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MATCH_CNT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  output logic             match_done,
  output logic             cand
);

  localparam int MW = cnt_w(MATCH_CNT);

  logic [MW-1:0] mcnt, mcnt_nxt;
  logic          cand_q, cand_nxt;
  logic          is_norm, is_swp, ori;

  assign is_norm = (&q0) & ~(|q1);
  assign is_swp  = ~(|q0) & (&q1);
  assign ori     = is_swp ? ORI_SWAP : ORI_NORM;

  always_comb begin
    mcnt_nxt = mcnt;
    cand_nxt = cand_q;
    if (!(is_norm || is_swp)) begin
      mcnt_nxt = '0;
    end else if ((mcnt == '0) || (ori != cand_q)) begin
      // A fresh run starts with this sample as its first match.
      mcnt_nxt = MW'(1);
      cand_nxt = ori;
    end else begin
      mcnt_nxt = mcnt + MW'(1);
    end
  end

  // Lock is decided on the updated count so the FSM leaves HUNT on the
  // same edge that registers the final matching sample.
  assign match_done = en && (mcnt_nxt == MW'(MATCH_CNT));
  assign cand       = cand_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt   <= '0;
      cand_q <= ORI_NORM;
    end else if (!en) begin
      mcnt   <= '0;
      cand_q <= ORI_NORM;
    end else begin
      mcnt   <= mcnt_nxt;
      cand_q <= cand_nxt;
    end
  end

endmodule

// File: rtl/iddr2_align_ctrl.sv
// Sequencing and alignment controller for a bank of WIDTH IDDR2 primitives.
// Pulses the IDDR2 reset, enables capture, trains on a "10" pattern to pick
// the Q0/Q1 order and then streams aligned 2-bit-per-lane words.
// Ports:
//   CLK, RST_N   : clock (also IDDR2 C0), asynchronous active-low reset
//   START        : pulse; starts training from IDLE, LOCKED or FAIL
//   Q0, Q1       : IDDR2 outputs, one bit per lane
//   IDDR_CE      : clock enable to every IDDR2
//   IDDR_R       : synchronous reset to every IDDR2
//   DOUT         : [2i+1] = late sample, [2i] = early sample of lane i
//   DVALID       : DOUT valid
//   DREADY       : downstream ready
//   OVF          : sticky, a valid word was dropped
//   LOCKED, SWAP : alignment achieved, Q1 is the early sample
//   FAIL         : training timed out
//   STATE        : FSM state (debug)
// Handshake: a word transfers on an edge where DVALID & DREADY. The source
// cannot stall, so an edge with DVALID & ~DREADY loses that word and sets
// OVF; a new word is presented every LOCKED cycle regardless of DREADY.
module iddr2_align_ctrl
  import iddr2_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int RST_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int MATCH_CNT    = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   Q0,
  input  logic [WIDTH-1:0]   Q1,
  output logic               IDDR_CE,
  output logic               IDDR_R,
  output logic [2*WIDTH-1:0] DOUT,
  output logic               DVALID,
  input  logic               DREADY,
  output logic               OVF,
  output logic               LOCKED,
  output logic               SWAP,
  output logic               FAIL,
  output logic [2:0]         STATE
);

  localparam int PW = cnt_w((RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES);
  localparam int TW = cnt_w(TIMEOUT);

  state_t              state;
  logic [PW-1:0]       pcnt;
  logic [TW-1:0]       tcnt;
  logic                match_done, det_cand, start_train;
  logic [2*WIDTH-1:0]  dout_nxt;

  assign STATE = state;

  // START is honoured only where training may (re)start.
  assign start_train = START &&
                       ((state == ST_IDLE) || (state == ST_LOCKED) || (state == ST_FAIL));

  iddr2_pattern_det #(
    .WIDTH     (WIDTH),
    .MATCH_CNT (MATCH_CNT)
  ) u_det (
    .clk        (CLK),
    .rst_n      (RST_N),
    .en         (state == ST_HUNT),
    .q0         (Q0),
    .q1         (Q1),
    .match_done (match_done),
    .cand       (det_cand)
  );

  always_comb begin
    dout_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dout_nxt[2*i]   = SWAP ? Q1[i] : Q0[i];
      dout_nxt[2*i+1] = SWAP ? Q0[i] : Q1[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      pcnt    <= '0;
      tcnt    <= '0;
      IDDR_CE <= 1'b0;
      IDDR_R  <= 1'b0;
      DOUT    <= '0;
      DVALID  <= 1'b0;
      OVF     <= 1'b0;
      LOCKED  <= 1'b0;
      SWAP    <= 1'b0;
      FAIL    <= 1'b0;
    end else begin
      DVALID <= 1'b0;
      if (DVALID && !DREADY) OVF <= 1'b1;

      if (start_train) begin
        state   <= ST_RESET;
        pcnt    <= '0;
        tcnt    <= '0;
        IDDR_R  <= 1'b1;
        IDDR_CE <= 1'b0;
        LOCKED  <= 1'b0;
        SWAP    <= 1'b0;
        FAIL    <= 1'b0;
        OVF     <= 1'b0;
      end else begin
        case (state)
          ST_RESET: begin
            if (pcnt == PW'(RST_CYCLES - 1)) begin
              state   <= ST_FLUSH;
              pcnt    <= '0;
              IDDR_R  <= 1'b0;
              IDDR_CE <= 1'b1;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
          ST_FLUSH: begin
            if (pcnt == PW'(FLUSH_CYCLES - 1)) begin
              state <= ST_HUNT;
              pcnt  <= '0;
              tcnt  <= '0;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
          ST_HUNT: begin
            // Lock takes priority over a timeout on the same cycle.
            if (match_done) begin
              state  <= ST_LOCKED;
              LOCKED <= 1'b1;
              SWAP   <= det_cand;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
              state   <= ST_FAIL;
              FAIL    <= 1'b1;
              IDDR_CE <= 1'b0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          ST_LOCKED: begin
            DOUT   <= dout_nxt;
            DVALID <= 1'b1;
          end
          ST_IDLE, ST_FAIL: begin
          end
          default: begin
            state   <= ST_IDLE;
            IDDR_CE <= 1'b0;
            IDDR_R  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
